// File: rtl/rr_arb_mux_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter/mux slice:
// state encoding and requester/select sizing.
package rr_arb_mux_8_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux8_bin.sv
// Generic 8:1 mux with a 3-bit binary select; lane i is i_din[i*K +: K].
module mux8_bin #(
    parameter int K = 1
) (
    input  logic [8*K-1:0] i_din,
    input  logic [2:0]     i_sel,
    output logic [K-1:0]   o_dout
);

    assign o_dout = i_din[i_sel*K +: K];

endmodule

// File: rtl/rr_pick_8.sv
// Combinational rotate-priority picker: returns the first requester at or
// after ptr (mod 8), plus a flag telling whether anyone is requesting.
module rr_pick_8
    import rr_arb_mux_8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] win
);

    // Walk from the furthest offset back toward ptr so the nearest hit wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        any = |req;
        win = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                win = ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux_8.sv
// Round-robin arbiter sharing one K-bit ready/valid channel among 8 producers;
// each grant lasts up to MAX_HOLD accepted beats, with one idle cycle between tenures.
module rr_arb_mux_8
    import rr_arb_mux_8_pkg::*;
#(
    parameter int K        = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [8*K-1:0]   din,
    input  logic             ready,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sb,
    output logic             valid,
    output logic [K-1:0]     out,
    output logic [3:0]       beat
);

    localparam logic [3:0] LAST_BEAT = 4'(MAX_HOLD - 1);

    state_t             r_state, w_state_nxt;
    logic [N_REQ-1:0]   r_gnt,   w_gnt_nxt;
    logic [SEL_W-1:0]   r_sb,    w_sb_nxt;
    logic [SEL_W-1:0]   r_ptr,   w_ptr_nxt;
    logic [3:0]         r_beat,  w_beat_nxt;

    logic               w_any;
    logic [SEL_W-1:0]   w_win;
    logic [K-1:0]       w_mux;
    logic               w_valid;
    logic               w_xfer;
    logic               w_release;

    rr_pick_8 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .win (w_win)
    );

    mux8_bin #(.K(K)) u_mux (
        .i_din  (din),
        .i_sel  (r_sb),
        .o_dout (w_mux)
    );

    // A withdrawn request ends the tenure without a transfer in that cycle.
    assign w_valid   = (r_state == GRANT) && req[r_sb];
    assign w_xfer    = w_valid && ready;
    assign w_release = (r_state == GRANT) &&
                       (!req[r_sb] || (w_xfer && (r_beat == LAST_BEAT)));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sb_nxt    = r_sb;
        w_ptr_nxt   = r_ptr;
        w_beat_nxt  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_sb_nxt    = w_win;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_beat_nxt  = 4'd0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_beat_nxt  = 4'd0;
                    w_ptr_nxt   = r_sb + SEL_W'(1);
                end else if (w_xfer) begin
                    w_beat_nxt  = r_beat + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sb    <= '0;
            r_ptr   <= '0;
            r_beat  <= 4'd0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sb    <= w_sb_nxt;
            r_ptr   <= w_ptr_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign sb    = r_sb;
    assign beat  = r_beat;
    assign valid = w_valid;
    assign out   = w_valid ? w_mux : '0;

endmodule
